// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset sequencer.
package mcu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  // ALU operation codes
  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_ADDU = 4'b1000;
  localparam logic [3:0] ALU_SUBU = 4'b1010;

  // Next-PC source select
  localparam logic [1:0] PCSRC_SEQ  = 2'd0;
  localparam logic [1:0] PCSRC_BEQ  = 2'd1;
  localparam logic [1:0] PCSRC_JUMP = 2'd2;
  localparam logic [1:0] PCSRC_JR   = 2'd3;

  // Register-file destination select
  localparam logic [1:0] REGDST_RT  = 2'd0;
  localparam logic [1:0] REGDST_RD  = 2'd1;
  localparam logic [1:0] REGDST_R31 = 2'd2;

  // Register-file write-data select
  localparam logic [1:0] MTR_ALU  = 2'd0;
  localparam logic [1:0] MTR_MEM  = 2'd1;
  localparam logic [1:0] MTR_LINK = 2'd2;
  localparam logic [1:0] MTR_IMM  = 2'd3;

  // Immediate extension mode
  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_LUI  = 2'd1;
  localparam logic [1:0] EXT_SIGN = 2'd2;

  // One-hot instruction flags as produced by the IR field decoder
  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic addi;
    logic addiu;
    logic slt;
    logic j;
    logic jal;
    logic jr;
  } flags_t;

  // True when exactly one instruction flag is set
  function automatic logic is_onehot(input flags_t f);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 13; i++) begin
      cnt = cnt + {3'b000, f[i]};
    end
    return (cnt == 4'd1);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Handshake/control bundle between the sequencer (master) and the datapath (slave).
interface multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic addu, subu, ori, lw, sw, beq, lui, addi, addiu, slt, j, jal, jr;
  logic zero;
  logic mem_ready;
  logic mem_req;
  logic IrWrite;
  logic PcWrite;
  logic [1:0] PcSrc;
  logic RegWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic MemWrite;
  logic ALUsrc;
  logic [3:0] ALUctr;
  logic [1:0] ExtOp;
  logic [2:0] state;
  logic illegal;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  addu, subu, ori, lw, sw, beq, lui, addi, addiu, slt, j, jal, jr,
    input  zero, mem_ready,
    output mem_req, IrWrite, PcWrite, PcSrc, RegWrite, RegDst, MemtoReg,
    output MemWrite, ALUsrc, ALUctr, ExtOp, state, illegal, instr_cnt
  );

  modport slave (
    output addu, subu, ori, lw, sw, beq, lui, addi, addiu, slt, j, jal, jr,
    output zero, mem_ready,
    input  mem_req, IrWrite, PcWrite, PcSrc, RegWrite, RegDst, MemtoReg,
    input  MemWrite, ALUsrc, ALUctr, ExtOp, state, illegal, instr_cnt
  );
endinterface

// File: rtl/multicycle_ctrl_field_dec.sv
// Combinational mapping from instruction flags to datapath field selects.
// The sequencer decides in which states these fields are actually driven.
module multicycle_field_dec
  import mcu_pkg::*;
(
  input  flags_t     i_flags,
  output logic       o_alusrc,
  output logic [3:0] o_aluctr,
  output logic [1:0] o_extop,
  output logic [1:0] o_regdst,
  output logic [1:0] o_memtoreg
);

  // Per-instruction field table; unlisted fields keep their idle values
  always_comb begin
    o_alusrc   = 1'b0;
    o_aluctr   = ALU_NONE;
    o_extop    = EXT_SIGN;
    o_regdst   = REGDST_RT;
    o_memtoreg = MTR_ALU;
    if (i_flags.addu) begin
      o_aluctr = ALU_ADDU;
      o_regdst = REGDST_RD;
    end else if (i_flags.subu) begin
      o_aluctr = ALU_SUBU;
      o_regdst = REGDST_RD;
    end else if (i_flags.slt) begin
      o_aluctr = ALU_SLT;
      o_regdst = REGDST_RD;
    end else if (i_flags.ori) begin
      o_alusrc = 1'b1;
      o_aluctr = ALU_OR;
      o_extop  = EXT_ZERO;
    end else if (i_flags.addi) begin
      o_alusrc = 1'b1;
      o_aluctr = ALU_ADD;
    end else if (i_flags.addiu) begin
      o_alusrc = 1'b1;
      o_aluctr = ALU_ADDU;
    end else if (i_flags.lui) begin
      o_extop    = EXT_LUI;
      o_memtoreg = MTR_IMM;
    end else if (i_flags.lw) begin
      o_alusrc   = 1'b1;
      o_aluctr   = ALU_ADD;
      o_memtoreg = MTR_MEM;
    end else if (i_flags.sw) begin
      o_alusrc = 1'b1;
      o_aluctr = ALU_ADD;
    end else if (i_flags.beq) begin
      o_aluctr = ALU_SUBU;
    end else if (i_flags.jal) begin
      o_regdst   = REGDST_R31;
      o_memtoreg = MTR_LINK;
    end else if (i_flags.j || i_flags.jr) begin
      // Pure PC redirects use no ALU/register fields
      o_aluctr = ALU_NONE;
    end else begin
      o_alusrc = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS-subset datapath.
// Outputs are Moore/Mealy decodes of the current state so that an asynchronous
// reset immediately presents FETCH values (mem_req high) on the bus.
module multicycle_ctrl
  import mcu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_retire;
  flags_t           w_flags;
  logic             w_onehot;
  logic             w_alu_cls;

  logic       w_dec_alusrc;
  logic [3:0] w_dec_aluctr;
  logic [1:0] w_dec_extop;
  logic [1:0] w_dec_regdst;
  logic [1:0] w_dec_memtoreg;

  logic       w_mem_req, w_irwrite, w_pcwrite, w_regwrite, w_memwrite;
  logic       w_alusrc, w_illegal;
  logic [1:0] w_pcsrc, w_regdst, w_memtoreg, w_extop;
  logic [3:0] w_aluctr;

  assign w_flags = {bus.addu, bus.subu, bus.ori, bus.lw, bus.sw, bus.beq, bus.lui,
                    bus.addi, bus.addiu, bus.slt, bus.j, bus.jal, bus.jr};
  assign w_onehot  = is_onehot(w_flags);
  assign w_alu_cls = w_flags.addu | w_flags.subu | w_flags.slt | w_flags.ori |
                     w_flags.addi | w_flags.addiu | w_flags.lui;

  multicycle_field_dec u_field_dec (
    .i_flags    (w_flags),
    .o_alusrc   (w_dec_alusrc),
    .o_aluctr   (w_dec_aluctr),
    .o_extop    (w_dec_extop),
    .o_regdst   (w_dec_regdst),
    .o_memtoreg (w_dec_memtoreg)
  );

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_retire) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Next-state and control-strobe decode; unreachable codes behave as FETCH
  always_comb begin
    w_next     = ST_FETCH;
    w_retire   = 1'b0;
    w_mem_req  = 1'b0;
    w_irwrite  = 1'b0;
    w_pcwrite  = 1'b0;
    w_pcsrc    = PCSRC_SEQ;
    w_regwrite = 1'b0;
    w_regdst   = REGDST_RT;
    w_memtoreg = MTR_ALU;
    w_memwrite = 1'b0;
    w_alusrc   = 1'b0;
    w_aluctr   = ALU_NONE;
    w_extop    = EXT_SIGN;
    w_illegal  = 1'b0;
    case (r_state)
      ST_DECODE: begin
        if (w_onehot) begin
          w_next = ST_EXEC;
        end else begin
          w_illegal = 1'b1;
          w_next    = ST_FETCH;
        end
      end
      ST_EXEC: begin
        w_alusrc = w_dec_alusrc;
        w_aluctr = w_dec_aluctr;
        w_extop  = w_dec_extop;
        if (w_alu_cls) begin
          w_next = ST_WB;
        end else if (w_flags.lw || w_flags.sw) begin
          w_next = ST_MEM;
        end else if (w_flags.beq) begin
          w_pcsrc   = PCSRC_BEQ;
          w_pcwrite = bus.zero;
          w_retire  = 1'b1;
        end else if (w_flags.j) begin
          w_pcsrc   = PCSRC_JUMP;
          w_pcwrite = 1'b1;
          w_retire  = 1'b1;
        end else if (w_flags.jr) begin
          w_pcsrc   = PCSRC_JR;
          w_pcwrite = 1'b1;
          w_retire  = 1'b1;
        end else if (w_flags.jal) begin
          w_pcsrc    = PCSRC_JUMP;
          w_pcwrite  = 1'b1;
          w_regwrite = 1'b1;
          w_regdst   = w_dec_regdst;
          w_memtoreg = w_dec_memtoreg;
          w_retire   = 1'b1;
        end else begin
          // Flags vanished after DECODE: drop the instruction unretired
          w_next = ST_FETCH;
        end
      end
      ST_MEM: begin
        w_mem_req  = 1'b1;
        w_memwrite = w_flags.sw;
        if (!bus.mem_ready) begin
          w_next = ST_MEM;
        end else if (w_flags.lw) begin
          w_next = ST_WB;
        end else begin
          w_retire = w_flags.sw;
          w_next   = ST_FETCH;
        end
      end
      ST_WB: begin
        w_regwrite = 1'b1;
        w_alusrc   = w_dec_alusrc;
        w_aluctr   = w_dec_aluctr;
        w_extop    = w_dec_extop;
        w_regdst   = w_dec_regdst;
        w_memtoreg = w_dec_memtoreg;
        w_retire   = 1'b1;
        w_next     = ST_FETCH;
      end
      default: begin
        // ST_FETCH and the unused encodings
        w_mem_req = 1'b1;
        if (bus.mem_ready) begin
          w_irwrite = 1'b1;
          w_pcwrite = 1'b1;
          w_pcsrc   = PCSRC_SEQ;
          w_next    = ST_DECODE;
        end else begin
          w_next = ST_FETCH;
        end
      end
    endcase
  end

  assign bus.mem_req   = w_mem_req;
  assign bus.IrWrite   = w_irwrite;
  assign bus.PcWrite   = w_pcwrite;
  assign bus.PcSrc     = w_pcsrc;
  assign bus.RegWrite  = w_regwrite;
  assign bus.RegDst    = w_regdst;
  assign bus.MemtoReg  = w_memtoreg;
  assign bus.MemWrite  = w_memwrite;
  assign bus.ALUsrc    = w_alusrc;
  assign bus.ALUctr    = w_aluctr;
  assign bus.ExtOp     = w_extop;
  assign bus.state     = r_state;
  assign bus.illegal   = w_illegal;
  assign bus.instr_cnt = r_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: two instances (32-bit and 4-bit
// counter) run in lockstep on the same stimulus.
module tb_multicycle_ctrl;

  localparam int OP_ADDU = 0, OP_SUBU = 1, OP_ORI = 2, OP_LW = 3, OP_SW = 4,
                 OP_BEQ = 5, OP_LUI = 6, OP_ADDI = 7, OP_ADDIU = 8, OP_SLT = 9,
                 OP_J = 10, OP_JAL = 11, OP_JR = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] flags;
  logic        zero;
  logic        mem_ready;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(32)) bus32 ();
  multicycle_ctrl_if #(.CNT_W(4))  bus4 ();

  assign bus32.addu  = flags[OP_ADDU];  assign bus4.addu  = flags[OP_ADDU];
  assign bus32.subu  = flags[OP_SUBU];  assign bus4.subu  = flags[OP_SUBU];
  assign bus32.ori   = flags[OP_ORI];   assign bus4.ori   = flags[OP_ORI];
  assign bus32.lw    = flags[OP_LW];    assign bus4.lw    = flags[OP_LW];
  assign bus32.sw    = flags[OP_SW];    assign bus4.sw    = flags[OP_SW];
  assign bus32.beq   = flags[OP_BEQ];   assign bus4.beq   = flags[OP_BEQ];
  assign bus32.lui   = flags[OP_LUI];   assign bus4.lui   = flags[OP_LUI];
  assign bus32.addi  = flags[OP_ADDI];  assign bus4.addi  = flags[OP_ADDI];
  assign bus32.addiu = flags[OP_ADDIU]; assign bus4.addiu = flags[OP_ADDIU];
  assign bus32.slt   = flags[OP_SLT];   assign bus4.slt   = flags[OP_SLT];
  assign bus32.j     = flags[OP_J];     assign bus4.j     = flags[OP_J];
  assign bus32.jal   = flags[OP_JAL];   assign bus4.jal   = flags[OP_JAL];
  assign bus32.jr    = flags[OP_JR];    assign bus4.jr    = flags[OP_JR];
  assign bus32.zero      = zero;      assign bus4.zero      = zero;
  assign bus32.mem_ready = mem_ready; assign bus4.mem_ready = mem_ready;

  multicycle_ctrl #(.CNT_W(32)) u_dut32 (.clk(clk), .reset(reset), .bus(bus32));
  multicycle_ctrl #(.CNT_W(4))  u_dut4  (.clk(clk), .reset(reset), .bus(bus4));

  typedef struct packed {
    logic [2:0] st;
    logic       req;
    logic       irw;
    logic       pcw;
    logic [1:0] pcsrc;
    logic       rw;
    logic [1:0] rdst;
    logic [1:0] mtr;
    logic       mw;
    logic       alusrc;
    logic [3:0] aluctr;
    logic [1:0] ext;
    logic       ill;
  } out_t;

  typedef struct packed {
    logic rdy;
    out_t o;
  } item_t;

  item_t       sbq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned exp_cnt  = 0;

  function automatic out_t idle(input logic [2:0] st);
    out_t o;
    o     = '0;
    o.st  = st;
    o.ext = 2'd2;
    return o;
  endfunction

  function automatic out_t sample32();
    out_t o;
    o = {bus32.state, bus32.mem_req, bus32.IrWrite, bus32.PcWrite, bus32.PcSrc,
         bus32.RegWrite, bus32.RegDst, bus32.MemtoReg, bus32.MemWrite, bus32.ALUsrc,
         bus32.ALUctr, bus32.ExtOp, bus32.illegal};
    return o;
  endfunction

  function automatic out_t sample4();
    out_t o;
    o = {bus4.state, bus4.mem_req, bus4.IrWrite, bus4.PcWrite, bus4.PcSrc,
         bus4.RegWrite, bus4.RegDst, bus4.MemtoReg, bus4.MemWrite, bus4.ALUsrc,
         bus4.ALUctr, bus4.ExtOp, bus4.illegal};
    return o;
  endfunction

  // Reference field table: {ALUsrc, ALUctr, ExtOp, RegDst(WB), MemtoReg(WB)}
  function automatic logic [10:0] fields(input int op);
    case (op)
      OP_ADDU:  return {1'b0, 4'b1000, 2'd2, 2'd1, 2'd0};
      OP_SUBU:  return {1'b0, 4'b1010, 2'd2, 2'd1, 2'd0};
      OP_SLT:   return {1'b0, 4'b0111, 2'd2, 2'd1, 2'd0};
      OP_ORI:   return {1'b1, 4'b0001, 2'd0, 2'd0, 2'd0};
      OP_ADDI:  return {1'b1, 4'b0010, 2'd2, 2'd0, 2'd0};
      OP_ADDIU: return {1'b1, 4'b1000, 2'd2, 2'd0, 2'd0};
      OP_LUI:   return {1'b0, 4'b0000, 2'd1, 2'd0, 2'd3};
      OP_LW:    return {1'b1, 4'b0010, 2'd2, 2'd0, 2'd1};
      OP_SW:    return {1'b1, 4'b0010, 2'd2, 2'd0, 2'd0};
      OP_BEQ:   return {1'b0, 4'b1010, 2'd2, 2'd0, 2'd0};
      default:  return {1'b0, 4'b0000, 2'd2, 2'd0, 2'd0};
    endcase
  endfunction

  task automatic push(input logic rdy, input out_t o, inout int k, input int max_cyc);
    item_t it;
    it.rdy = rdy;
    it.o   = o;
    if (k < max_cyc) sbq.push_back(it);
    k++;
  endtask

  // Drive flags/zero and push the expected per-cycle outputs of one instruction
  task automatic build(input logic [12:0] f, input int fw, input int mw,
                       input logic z, input int max_cyc);
    out_t        o;
    int          op = -1;
    int          k = 0;
    logic [10:0] fl;
    logic        retire = 1'b0;
    flags = f;
    zero  = z;
    if ($countones(f) == 1) begin
      for (int i = 0; i < 13; i++) if (f[i]) op = i;
    end
    o = idle(3'd0); o.req = 1'b1;
    for (int i = 0; i < fw; i++) push(1'b0, o, k, max_cyc);
    o.irw = 1'b1; o.pcw = 1'b1;
    push(1'b1, o, k, max_cyc);
    o = idle(3'd1);
    if (op < 0) begin
      o.ill = 1'b1;
      push(1'($urandom_range(0, 1)), o, k, max_cyc);
    end else begin
      push(1'($urandom_range(0, 1)), o, k, max_cyc);
      fl = fields(op);
      o = idle(3'd2);
      o.alusrc = fl[10]; o.aluctr = fl[9:6]; o.ext = fl[5:4];
      case (op)
        OP_BEQ: begin o.pcsrc = 2'd1; o.pcw = z; retire = 1'b1; end
        OP_J:   begin o.pcsrc = 2'd2; o.pcw = 1'b1; retire = 1'b1; end
        OP_JR:  begin o.pcsrc = 2'd3; o.pcw = 1'b1; retire = 1'b1; end
        OP_JAL: begin
          o.pcsrc = 2'd2; o.pcw = 1'b1; o.rw = 1'b1; o.rdst = 2'd2; o.mtr = 2'd2;
          retire = 1'b1;
        end
        default: ;
      endcase
      push(1'($urandom_range(0, 1)), o, k, max_cyc);
      if (!retire && (op == OP_LW || op == OP_SW)) begin
        o = idle(3'd3); o.req = 1'b1; o.mw = (op == OP_SW);
        for (int i = 0; i < mw; i++) push(1'b0, o, k, max_cyc);
        push(1'b1, o, k, max_cyc);
        if (op == OP_SW) retire = 1'b1;
      end
      if (!retire) begin
        o = idle(3'd4);
        o.alusrc = fl[10]; o.aluctr = fl[9:6]; o.ext = fl[5:4];
        o.rw = 1'b1; o.rdst = fl[3:2]; o.mtr = fl[1:0];
        push(1'($urandom_range(0, 1)), o, k, max_cyc);
        retire = 1'b1;
      end
    end
    if (retire && k <= max_cyc) exp_cnt++;
  endtask

  // Pop one expected cycle at a time, apply its mem_ready, compare mid-cycle
  task automatic drain(input string name);
    item_t it;
    out_t  o32, o4;
    int    cyc = 0;
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      mem_ready = it.rdy;
      @(negedge clk);
      o32 = sample32();
      o4  = sample4();
      n_checks++;
      if (o32 !== it.o || o4 !== it.o) begin
        n_fail++;
        $display("FAIL %s cycle %0d: outputs dut32=%h dut4=%h expected=%h",
                 name, cyc, o32, o4, it.o);
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic check_end(input string name);
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (bus32.instr_cnt !== exp_cnt[31:0] || bus4.instr_cnt !== exp_cnt[3:0] ||
        bus32.state !== 3'd0) begin
      n_fail++;
      $display("FAIL %s end: cnt32=%0d cnt4=%0d state=%0d expected cnt=%0d/%0d state=0",
               name, bus32.instr_cnt, bus4.instr_cnt, bus32.state,
               exp_cnt[31:0], exp_cnt[3:0]);
    end
  endtask

  task automatic run(input string name, input int op, input int fw, input int mw, input logic z);
    logic [12:0] f;
    f = 13'd0;
    f[op] = 1'b1;
    build(f, fw, mw, z, 100);
    drain(name);
    check_end(name);
  endtask

  task automatic check_reset_state(input string name);
    out_t e;
    e = idle(3'd0); e.req = 1'b1;
    n_checks++;
    if (sample32() !== e || sample4() !== e ||
        bus32.instr_cnt !== 32'd0 || bus4.instr_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL %s: outputs=%h cnt32=%0d cnt4=%0d expected outputs=%h cnt=0",
               name, sample32(), bus32.instr_cnt, bus4.instr_cnt, e);
    end
  endtask

  task automatic test_reset();
    out_t o;
    int   k = 0;
    reset = 1'b1; flags = 13'd0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset_hold");
    reset = 1'b0;
    o = idle(3'd0); o.req = 1'b1;
    push(1'b0, o, k, 100);
    push(1'b0, o, k, 100);
    drain("after_reset_fetch_wait");
  endtask

  task automatic test_alu_ops();
    run("addu", OP_ADDU, 0, 0, 1'b0);
    run("subu", OP_SUBU, 1, 0, 1'b1);
    run("slt", OP_SLT, 0, 0, 1'b0);
    run("ori", OP_ORI, 0, 0, 1'b1);
    run("addi", OP_ADDI, 2, 0, 1'b0);
    run("addiu", OP_ADDIU, 0, 0, 1'b0);
    run("lui", OP_LUI, 0, 0, 1'b1);
    run("sw", OP_SW, 0, 0, 1'b0);
    run("sw_wait", OP_SW, 1, 2, 1'b1);
  endtask

  task automatic test_lw();
    build(13'd1 << OP_LW, 2, 1, 1'b0, 100);
    n_checks++;
    if (sbq.size() != 8) begin
      n_fail++;
      $display("FAIL lw_len: model cycles=%0d required=8", sbq.size());
    end
    drain("lw_waits");
    check_end("lw_waits");
    run("lw_nowait", OP_LW, 0, 0, 1'b1);
  endtask

  task automatic test_beq();
    run("beq_z0", OP_BEQ, 0, 0, 1'b0);
    run("beq_z1", OP_BEQ, 0, 0, 1'b1);
  endtask

  task automatic test_jumps();
    run("j", OP_J, 0, 0, 1'b0);
    run("jal", OP_JAL, 1, 0, 1'b1);
    run("jr", OP_JR, 0, 0, 1'b0);
  endtask

  task automatic test_illegal();
    build(13'd0, 0, 0, 1'b0, 100);
    drain("illegal_none");
    check_end("illegal_none");
    build((13'd1 << OP_LW) | (13'd1 << OP_SW), 1, 0, 1'b0, 100);
    drain("illegal_lw_sw");
    check_end("illegal_lw_sw");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      run("b2b", $urandom_range(0, 12), $urandom_range(0, 2), $urandom_range(0, 2),
          1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid(input string name, input int op);
    build(13'd1 << op, 0, 3, 1'b0, 4);
    drain(name);
    mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    exp_cnt = 0;
    check_reset_state(name);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) run("wrap_j", OP_J, 0, 0, 1'b0);
    n_checks++;
    if (bus4.instr_cnt !== 4'd0 || bus32.instr_cnt !== 32'd16) begin
      n_fail++;
      $display("FAIL wrap: cnt4=%0d cnt32=%0d expected 0 and 16",
               bus4.instr_cnt, bus32.instr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_lw();
    test_beq();
    test_jumps();
    test_illegal();
    test_back_to_back();
    test_reset_mid("reset_mid_lw", OP_LW);
    test_reset_mid("reset_mid_sw", OP_SW);
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
